// File: rtl/signal_creator_3.sv
// signal_creator_3: free-running serial pattern generator.
// Shifts out bits [LEN-1:0] of PATTERN, MSB first, on a registered 1-bit
// output and repeats with no gap at the wrap point.
// Optional build macro SIGNAL_CREATOR_SYNC_EN adds a registered frame marker
// "sync" that is high in the cycle where out carries the first pattern bit.
module signal_creator_3 #(
    parameter int          LEN     = 8,              // pattern length, 2..32
    parameter logic [31:0] PATTERN = 32'h0000_00D2   // only [LEN-1:0] used
) (
    input  logic clk,
    input  logic rst,
`ifdef SIGNAL_CREATOR_SYNC_EN
    output logic sync,
`endif
    output logic out
);

    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

    // Pattern reordered so that position 0 holds the first bit to emit.
    logic [LEN-1:0] seq;

    generate
        for (genvar gi = 0; gi < LEN; gi++) begin : g_seq
            assign seq[gi] = PATTERN[LEN-1-gi];
        end
    endgenerate

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_q, out_d;
`ifdef SIGNAL_CREATOR_SYNC_EN
    logic             sync_q, sync_d;
`endif

    // Next-state: emit the current bit and advance the index, wrapping at LEN-1
    // so non-power-of-two lengths never reach an unused index.
    always_comb begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        out_d = seq[idx_q];
`ifdef SIGNAL_CREATOR_SYNC_EN
        sync_d = (idx_q == '0);
`endif
    end

    // State registers with synchronous reset; reset restarts from the first bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            out_q <= 1'b0;
`ifdef SIGNAL_CREATOR_SYNC_EN
            sync_q <= 1'b0;
`endif
        end else begin
            idx_q <= idx_d;
            out_q <= out_d;
`ifdef SIGNAL_CREATOR_SYNC_EN
            sync_q <= sync_d;
`endif
        end
    end

    assign out = out_q;
`ifdef SIGNAL_CREATOR_SYNC_EN
    assign sync = sync_q;
`endif

endmodule

// File: tb/tb_signal_creator_3.sv
// Testbench for signal_creator_3: several parameterisations share one clock
// and reset; a run-edge-count model predicts every output each cycle, and
// directed literal vectors pin the expected sequences.
`timescale 1ns/1ps
module tb_signal_creator_3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic out_def, out_l5, out_z, out_f, out_l2;
`ifdef SIGNAL_CREATOR_SYNC_EN
    logic sync_def, sync_l5, sync_z, sync_f, sync_l2;
`endif

    signal_creator_3 u_def (
        .clk(clk), .rst(rst),
`ifdef SIGNAL_CREATOR_SYNC_EN
        .sync(sync_def),
`endif
        .out(out_def));

    signal_creator_3 #(.LEN(5), .PATTERN(32'h0000_0013)) u_l5 (
        .clk(clk), .rst(rst),
`ifdef SIGNAL_CREATOR_SYNC_EN
        .sync(sync_l5),
`endif
        .out(out_l5));

    signal_creator_3 #(.LEN(4), .PATTERN(32'h0000_0000)) u_z (
        .clk(clk), .rst(rst),
`ifdef SIGNAL_CREATOR_SYNC_EN
        .sync(sync_z),
`endif
        .out(out_z));

    signal_creator_3 #(.LEN(4), .PATTERN(32'h0000_000F)) u_f (
        .clk(clk), .rst(rst),
`ifdef SIGNAL_CREATOR_SYNC_EN
        .sync(sync_f),
`endif
        .out(out_f));

    signal_creator_3 #(.LEN(2), .PATTERN(32'h0000_0001)) u_l2 (
        .clk(clk), .rst(rst),
`ifdef SIGNAL_CREATOR_SYNC_EN
        .sync(sync_l2),
`endif
        .out(out_l2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Model: k = number of run edges since the last reset edge (0 = in reset).
    int  k = 0;
    bit  seen_edge = 0;

    always @(posedge clk) begin
        seen_edge = 1;
        if (rst) k = 0;
        else     k = k + 1;
    end

    function automatic logic exp_out(input int len, input int pat, input int kk);
        int pos;
        if (kk == 0) return 1'b0;
        pos = len - 1 - ((kk - 1) % len);
        return pat[pos];
    endfunction

    function automatic logic exp_sync(input int len, input int kk);
        return (kk >= 1) && (((kk - 1) % len) == 0);
    endfunction

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (seen_edge) begin
            chk("model_def", out_def, exp_out(8, 32'hD2, k));
            chk("model_l5",  out_l5,  exp_out(5, 32'h13, k));
            chk("model_z",   out_z,   exp_out(4, 32'h0,  k));
            chk("model_f",   out_f,   exp_out(4, 32'hF,  k));
            chk("model_l2",  out_l2,  exp_out(2, 32'h1,  k));
`ifdef SIGNAL_CREATOR_SYNC_EN
            chk("model_sync_def", sync_def, exp_sync(8, k));
            chk("model_sync_l5",  sync_l5,  exp_sync(5, k));
            chk("model_sync_l2",  sync_l2,  exp_sync(2, k));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic lit_def [16] = '{1,1,0,1,0,0,1,0, 1,1,0,1,0,0,1,0};
    logic lit_l5  [10] = '{1,0,0,1,1, 1,0,0,1,1};
    logic lit_mid [5]  = '{1,1,0,1,0};
    logic lit_l2  [4]  = '{0,1,0,1};

    initial begin
        rst = 1'b1;
        // Reset held for 3 edges: all outputs low.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_def", out_def, 1'b0);
            chk("rst_f",   out_f,   1'b0);
`ifdef SIGNAL_CREATOR_SYNC_EN
            chk("rst_sync", sync_def, 1'b0);
`endif
        end

        // Release: default sequence over 24 edges, wrap checked literally.
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i < 16) chk("lit_def", out_def, lit_def[i]);
            if (i < 10) chk("lit_l5",  out_l5,  lit_l5[i]);
            if (i < 4)  chk("lit_l2",  out_l2,  lit_l2[i]);
            chk("lit_z", out_z, 1'b0);
            chk("lit_f", out_f, 1'b1);
`ifdef SIGNAL_CREATOR_SYNC_EN
            chk("lit_sync", sync_def, (i == 0 || i == 8 || i == 16) ? 1'b1 : 1'b0);
`endif
        end

        // Mid-sequence reset: restart from the first bit.
        rst = 1'b1;
        tick();
        chk("mid_rst0", out_def, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_run", out_def, lit_mid[i]);
        end
        rst = 1'b1;
        tick();
        chk("mid_rst1", out_def, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_restart", out_def, lit_def[i]);
        end

        // Long reset hold: outputs stay low.
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_def", out_def, 1'b0);
            chk("hold_f",   out_f,   1'b0);
        end

        // Long free run, checked by the model only.
        rst = 1'b0;
        for (int i = 0; i < 45; i++) tick();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
